serial_multiply_uu: RTL and testbench

//   Unsigned serial shift-and-add multiply-accumulate: product = multiplicand*multiplier + addend,
//   one multiplier bit per enabled clock. Inverse of serial_divide_uu: in the divider bench it

---
 rtl/serial_multiply_uu.sv | 101 ++++++++++
 tb/tb_serial_multiply_uu.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_multiply_uu.sv
// Unsigned serial shift-and-add multiply-accumulate: product = multiplicand * multiplier + addend.
// One multiplier bit is consumed per enabled clock, LSB first, with a start/busy/done handshake.
module serial_multiply_uu #(
  parameter int unsigned M_PP           = 16,
  parameter int unsigned N_PP           = 8,
  parameter int unsigned COUNT_WIDTH_PP = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clk_en_i,
  input  logic                   multiply_i,
  input  logic [M_PP-1:0]        multiplicand_i,
  input  logic [N_PP-1:0]        multiplier_i,
  input  logic [N_PP-1:0]        addend_i,
  output logic [M_PP+N_PP-1:0]   product_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int unsigned W = M_PP + N_PP;
  localparam logic [COUNT_WIDTH_PP-1:0] LastCount = COUNT_WIDTH_PP'(N_PP - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                    state_q, state_d;
  logic [W-1:0]              a_q, a_d;
  logic [N_PP-1:0]           b_q, b_d;
  logic [W-1:0]              acc_q, acc_d;
  logic [COUNT_WIDTH_PP-1:0] cnt_q, cnt_d;
  logic [W-1:0]              product_q, product_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [W-1:0]              acc_next;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (clk_en_i) begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // The accumulator is M+N bits wide, which can hold the largest A*B+C without overflow.
  assign acc_next = acc_q + (b_q[0] ? a_q : '0);

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = done_q;
    unique case (state_q)
      StIdle: begin
        if (multiply_i) begin
          state_d = StRun;
          a_d     = W'(multiplicand_i);
          b_d     = multiplier_i;
          acc_d   = W'(addend_i);
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      StRun: begin
        acc_d = acc_next;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + COUNT_WIDTH_PP'(1);
        if (cnt_q == LastCount) begin
          product_d = acc_next;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign product_o = product_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_serial_multiply_uu.sv
// Self-checking bench for serial_multiply_uu: directed scenarios plus randomized operands
// checked against a plain-arithmetic A*B+C model and a divide/modulo round trip.
module tb_serial_multiply_uu;

  localparam int unsigned M = 16;
  localparam int unsigned N = 8;
  localparam int unsigned W = M + N;
  localparam int Bound = 100;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clk_en = 1'b1;
  logic         multiply = 1'b0;
  logic [M-1:0] multiplicand = '0;
  logic [N-1:0] multiplier = '0;
  logic [N-1:0] addend = '0;
  logic [W-1:0] product;
  logic         busy;
  logic         done;

  int checks = 0;
  int failures = 0;

  serial_multiply_uu #(
    .M_PP          (M),
    .N_PP          (N),
    .COUNT_WIDTH_PP(5)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .clk_en_i      (clk_en),
    .multiply_i    (multiply),
    .multiplicand_i(multiplicand),
    .multiplier_i  (multiplier),
    .addend_i      (addend),
    .product_o     (product),
    .busy_o        (busy),
    .done_o        (done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input longint unsigned a, input longint unsigned b,
                                         input longint unsigned c);
    longint unsigned r;
    r = a * b + c;
    return r[W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse a start for one enabled edge, then count enabled edges until done (bounded).
  task automatic run_op(input logic [M-1:0] a, input logic [N-1:0] b, input logic [N-1:0] c,
                        output int edges);
    multiplicand = a;
    multiplier   = b;
    addend       = c;
    multiply     = 1'b1;
    tick();
    multiply     = 1'b0;
    multiplicand = M'($urandom);
    multiplier   = N'($urandom);
    addend       = N'($urandom);
    edges = 0;
    while (!done && edges < Bound) begin
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    checks++;
    if (product !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: product=%h busy=%b done=%b, required 0/0/0", product, busy, done);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int edges;
    run_op(16'd0, 8'd1, 8'd0, edges);
    checks++;
    if (edges !== int'(N) || done !== 1'b1 || product !== '0) begin
      failures++;
      $display("FAIL zero_product: edges=%0d done=%b product=%h, required %0d/1/0",
               edges, done, product, N);
    end
    run_op(16'hFFFF, 8'hFF, 8'hFF, edges);
    checks++;
    if (product !== 24'hFF0000) begin
      failures++;
      $display("FAIL max_operands: product=%h, required ff0000", product);
    end
    run_op(16'd1234, 8'd7, 8'd3, edges);
    checks++;
    if (product !== 24'd8641) begin
      failures++;
      $display("FAIL small_mac: product=%0d, required 8641", product);
    end
  endtask

  task automatic test_random();
    int edges;
    logic [M-1:0] a;
    logic [N-1:0] b, c;
    logic [W-1:0] exp;
    for (int i = 0; i < 40; i++) begin
      a = M'($urandom);
      b = N'($urandom);
      c = N'($urandom);
      if (i % 8 == 0) b = '0;
      exp = model(a, b, c);
      run_op(a, b, c, edges);
      checks++;
      if (product !== exp || edges !== int'(N) || busy !== 1'b0) begin
        failures++;
        $display("FAIL random_mac: a=%0d b=%0d c=%0d product=%0d edges=%0d busy=%b, required %0d/%0d/0",
                 a, b, c, product, edges, busy, exp, N);
      end
    end
  endtask

  task automatic test_gating();
    int edges;
    int clocks;
    logic [W-1:0] prev;
    prev = product;
    multiplicand = 16'd100;
    multiplier   = 8'd3;
    addend       = 8'd0;
    multiply     = 1'b1;
    tick();
    multiply = 1'b0;
    clocks = 0;
    edges  = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      clocks++;
      edges++;
    end
    clk_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      clocks++;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || product !== prev) begin
        failures++;
        $display("FAIL gated_freeze: busy=%b done=%b product=%h, required 1/0/%h",
                 busy, done, product, prev);
      end
    end
    clk_en = 1'b1;
    while (!done && clocks < Bound) begin
      tick();
      clocks++;
    end
    checks++;
    if (clocks !== 13 || product !== 24'd300 || done !== 1'b1) begin
      failures++;
      $display("FAIL gated_latency: clocks=%0d product=%0d done=%b, required 13/300/1",
               clocks, product, done);
    end
  endtask

  task automatic test_busy_reject();
    int edges;
    multiplicand = 16'd5;
    multiplier   = 8'd5;
    addend       = 8'd0;
    multiply     = 1'b1;
    tick();
    multiply = 1'b0;
    tick();
    tick();
    multiplicand = 16'd9;
    multiplier   = 8'd9;
    multiply     = 1'b1;
    tick();
    multiply = 1'b0;
    edges = 3;
    while (!done && edges < Bound) begin
      tick();
      edges++;
    end
    checks++;
    if (product !== 24'd25 || edges !== int'(N)) begin
      failures++;
      $display("FAIL busy_reject: product=%0d edges=%0d, required 25/%0d", product, edges, N);
    end
    run_op(16'd9, 8'd9, 8'd0, edges);
    checks++;
    if (product !== 24'd81) begin
      failures++;
      $display("FAIL after_reject: product=%0d, required 81", product);
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    multiplicand = 16'd321;
    multiplier   = 8'd45;
    addend       = 8'd6;
    multiply     = 1'b1;
    edges = 0;
    tick();
    while (!done && edges < Bound) begin
      tick();
      edges++;
    end
    checks++;
    if (product !== model(321, 45, 6) || edges !== int'(N)) begin
      failures++;
      $display("FAIL b2b_first: product=%0d edges=%0d, required %0d/%0d",
               product, edges, model(321, 45, 6), N);
    end
    multiplicand = 16'd777;
    multiplier   = 8'd200;
    addend       = 8'd17;
    tick();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || product !== model(321, 45, 6)) begin
      failures++;
      $display("FAIL b2b_restart: busy=%b done=%b product=%0d, required 1/0/%0d",
               busy, done, product, model(321, 45, 6));
    end
    multiply = 1'b0;
    edges = 0;
    while (!done && edges < Bound) begin
      tick();
      edges++;
    end
    checks++;
    if (product !== model(777, 200, 17) || edges !== int'(N)) begin
      failures++;
      $display("FAIL b2b_second: product=%0d edges=%0d, required %0d/%0d",
               product, edges, model(777, 200, 17), N);
    end
  endtask

  task automatic test_reset_mid();
    int edges;
    multiplicand = 16'd50;
    multiplier   = 8'd50;
    addend       = 8'd0;
    multiply     = 1'b1;
    tick();
    multiply = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (product !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: product=%h busy=%b done=%b, required 0/0/0", product, busy, done);
    end
    tick();
    rst = 1'b1;
    tick();
    run_op(16'd50, 8'd50, 8'd7, edges);
    checks++;
    if (product !== 24'd2507 || edges !== int'(N)) begin
      failures++;
      $display("FAIL post_reset_op: product=%0d edges=%0d, required 2507/%0d", product, edges, N);
    end
  endtask

  task automatic test_round_trip();
    int edges;
    int bad;
    logic [M-1:0] dividend, quotient;
    logic [N-1:0] divisor, remainder;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      dividend  = M'($urandom);
      divisor   = N'($urandom_range(1, 255));
      quotient  = dividend / M'(divisor);
      remainder = N'(dividend % M'(divisor));
      run_op(quotient, divisor, remainder, edges);
      checks++;
      if (product[M-1:0] !== dividend || product[W-1:M] !== '0 || edges !== int'(N)) begin
        failures++;
        if (bad < 10)
          $display("FAIL round_trip: dividend=%0d divisor=%0d product=%0d edges=%0d, required %0d/%0d",
                   dividend, divisor, product, edges, dividend, N);
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_gating();
    test_busy_reject();
    test_back_to_back();
    test_reset_mid();
    test_round_trip();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
